// File: rtl/n64_uart_pkg.sv
// Shared types and helpers for the controller-snapshot UART framer.
// Holds the packet geometry, the FSM encoding and the checksum rule.
package n64_uart_pkg;

  localparam int PKT_LEN = 6;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [2:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(PKT_LEN - 1);

  function automatic logic [7:0] checksum(input logic [31:0] d);
    return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

endpackage

// File: rtl/cntlr_uart_framer.sv
// Frames 32-bit controller snapshots into 6-byte packets (sync, 4 data bytes
// MSB-first, XOR checksum) and streams them to a UART TX, with a one-deep pending buffer.
module cntlr_uart_framer
  import n64_uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter bit         CHANGE_ONLY = 1'b0,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cntlr_data,
  input  logic             cntlr_data_rdy,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             pkt_sent,
  output logic [CNT_W-1:0] drop_cnt,
  output state_t           state_dbg
);

  // Handshake: a byte moves when tx_valid && tx_ready are both high at a rising
  // clk edge; tx_valid/tx_data hold stable until then, tx_ready alone means nothing.

  state_t      state;
  idx_t        idx;
  logic [31:0] pkt_q;
  logic [31:0] pend_q;
  logic        pend_full;
  logic [31:0] last_q;

  logic rdy_eff;
  logic hs;
  logic last_hs;

  // Repeated snapshots are dropped before they touch any state when CHANGE_ONLY is set.
  assign rdy_eff  = cntlr_data_rdy && !(CHANGE_ONLY && (cntlr_data == last_q));
  assign hs       = (state == SEND) && tx_ready;
  assign last_hs  = hs && (idx == LAST_IDX);

  assign tx_valid  = (state == SEND);
  assign busy      = (state == SEND) || pend_full;
  assign state_dbg = state;

  always_comb begin
    tx_data = '0;
    if (state == SEND) begin
      case (idx)
        3'd0:    tx_data = SYNC_BYTE;
        3'd1:    tx_data = pkt_q[31:24];
        3'd2:    tx_data = pkt_q[23:16];
        3'd3:    tx_data = pkt_q[15:8];
        3'd4:    tx_data = pkt_q[7:0];
        3'd5:    tx_data = checksum(pkt_q);
        default: tx_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pkt_q     <= '0;
      pend_q    <= '0;
      pend_full <= 1'b0;
      last_q    <= '0;
      drop_cnt  <= '0;
      pkt_sent  <= 1'b0;
    end else begin
      pkt_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (rdy_eff) begin
            pkt_q  <= cntlr_data;
            last_q <= cntlr_data;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (idx != LAST_IDX) begin
              idx <= idx + 1'b1;
            end else begin
              idx      <= '0;
              pkt_sent <= 1'b1;
              if (pend_full) pkt_q <= pend_q;
              else if (rdy_eff) pkt_q <= cntlr_data;
              else state <= IDLE;
            end
          end
          // A snapshot lands in pending unless the final handshake took it directly.
          if (rdy_eff) begin
            last_q <= cntlr_data;
            if (!(last_hs && !pend_full)) begin
              pend_q <= cntlr_data;
              if (pend_full && !last_hs && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
            end
          end
          if (last_hs && pend_full) pend_full <= rdy_eff;
          else if (rdy_eff && !last_hs) pend_full <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cntlr_uart_framer.sv
// Directed bench for cntlr_uart_framer: one default instance plus a CHANGE_ONLY instance,
// with a byte scoreboard on the default instance's TX handshake.
module tb_cntlr_uart_framer;
  import n64_uart_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // default instance
  logic [31:0] cntlr_data = '0;
  logic        cntlr_data_rdy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        pkt_sent;
  logic [7:0]  drop_cnt;
  state_t      state_dbg;

  // CHANGE_ONLY instance
  logic [31:0] cntlr_data_b = '0;
  logic        cntlr_data_rdy_b = 1'b0;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b;
  logic        tx_ready_b = 1'b1;
  logic        busy_b;
  logic        pkt_sent_b;
  logic [7:0]  drop_cnt_b;
  state_t      state_dbg_b;

  cntlr_uart_framer #(.SYNC_BYTE(8'hA5), .CHANGE_ONLY(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cntlr_data(cntlr_data), .cntlr_data_rdy(cntlr_data_rdy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .pkt_sent(pkt_sent), .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  cntlr_uart_framer #(.SYNC_BYTE(8'hA5), .CHANGE_ONLY(1'b1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .cntlr_data(cntlr_data_b), .cntlr_data_rdy(cntlr_data_rdy_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b),
    .pkt_sent(pkt_sent_b), .drop_cnt(drop_cnt_b), .state_dbg(state_dbg_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] b_got[$];
  bit sb_en = 1'b1;
  int cyc = 0;
  int hs_cnt = 0;
  int first_hs = 0;
  int last_hs = 0;
  int sent_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] d);
    return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    cyc++;
    if (sb_en && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
      else check("sb_byte", tx_data, exp_q.pop_front());
      if (hs_cnt == 0) first_hs = cyc;
      last_hs = cyc;
      hs_cnt++;
    end
    if (pkt_sent) sent_cnt++;
    if (tx_valid_b && tx_ready_b) b_got.push_back(tx_data_b);
  end

  // driver tasks
  task automatic push_pkt(input logic [31:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(xor4(d));
  endtask

  task automatic pulse_rdy(input logic [31:0] d);
    cntlr_data = d;
    cntlr_data_rdy = 1'b1;
    @(posedge clk); #1;
    cntlr_data_rdy = 1'b0;
  endtask

  task automatic pulse_rdy_b(input logic [31:0] d);
    cntlr_data_b = d;
    cntlr_data_rdy_b = 1'b1;
    @(posedge clk); #1;
    cntlr_data_rdy_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_stats();
    hs_cnt = 0;
    sent_cnt = 0;
  endtask

  // Steps cycles until the default instance is idle; bp selects the 1,0,0,1 ready pattern.
  task automatic run_until_idle(input int budget, input bit bp);
    bit [3:0] pat = 4'b1001;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tx_ready = bp ? pat[c % 4] : 1'b1;
      @(negedge clk);
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (!busy && !tx_valid && exp_q.size() == 0) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("idle_timeout", done, 1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [7:0] sp[6];
  logic [7:0] sb[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_sent", pkt_sent, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", state_dbg, IDLE);
    @(posedge clk); #1;

    // single packet, tx_ready held high
    clear_stats();
    sp = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    push_pkt(32'h1234ABCD);
    tx_ready = 1'b1;
    pulse_rdy(32'h1234ABCD);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("single_valid", tx_valid, 1);
      check("single_byte", tx_data, sp[k]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("single_done_valid", tx_valid, 0);
    check("single_pkt_sent", pkt_sent, 1);
    @(posedge clk); #1;
    run_until_idle(20, 1'b0);
    check("single_sent_cnt", sent_cnt, 1);
    check("single_hs_cnt", hs_cnt, 6);
    check("single_span", last_hs - first_hs, 5);

    // backpressure with tx_ready 1,0,0,1
    clear_stats();
    push_pkt(32'h1234ABCD);
    pulse_rdy(32'h1234ABCD);
    run_until_idle(100, 1'b1);
    check("bp_sent_cnt", sent_cnt, 1);
    check("bp_hs_cnt", hs_cnt, 6);
    check("bp_drop_cnt", drop_cnt, 0);

    // pending buffer overwrite and back-to-back second packet
    clear_stats();
    push_pkt(32'h00000001);
    push_pkt(32'h00000003);
    tx_ready = 1'b1;
    pulse_rdy(32'h00000001);
    @(posedge clk); #1;
    cntlr_data = 32'h00000002;
    cntlr_data_rdy = 1'b1;
    @(posedge clk); #1;
    cntlr_data = 32'h00000003;
    @(posedge clk); #1;
    cntlr_data_rdy = 1'b0;
    @(negedge clk);
    check("pend_busy", busy, 1);
    check("pend_drop_cnt", drop_cnt, 1);
    @(posedge clk); #1;
    run_until_idle(60, 1'b0);
    check("pend_hs_cnt", hs_cnt, 12);
    check("pend_span", last_hs - first_hs, 11);
    check("pend_sent_cnt", sent_cnt, 2);
    check("pend_drop_final", drop_cnt, 1);

    // rdy coincident with the checksum handshake, pending empty
    do_reset();
    clear_stats();
    push_pkt(32'h0F0F55AA);
    push_pkt(32'h89ABCDEF);
    tx_ready = 1'b1;
    pulse_rdy(32'h0F0F55AA);
    repeat (5) begin
      @(posedge clk); #1;
    end
    cntlr_data = 32'h89ABCDEF;
    cntlr_data_rdy = 1'b1;
    @(negedge clk);
    check("edge_chk_byte", tx_data, 8'hFF);
    @(posedge clk); #1;
    cntlr_data_rdy = 1'b0;
    @(negedge clk);
    check("edge_valid", tx_valid, 1);
    check("edge_sync", tx_data, 8'hA5);
    check("edge_pkt_sent", pkt_sent, 1);
    check("edge_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    run_until_idle(40, 1'b0);
    check("edge_hs_cnt", hs_cnt, 12);
    check("edge_span", last_hs - first_hs, 11);
    check("edge_drop_final", drop_cnt, 0);

    // CHANGE_ONLY instance: repeated identical snapshots give one packet
    b_got.delete();
    sb = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    pulse_rdy_b(32'hDEADBEEF);
    @(posedge clk); #1;
    pulse_rdy_b(32'hDEADBEEF);
    repeat (10) begin
      @(posedge clk); #1;
    end
    pulse_rdy_b(32'hDEADBEEF);
    repeat (10) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("chg_byte_cnt", b_got.size(), 6);
    for (int k = 0; k < 6 && k < b_got.size(); k++) check("chg_byte", b_got[k], sb[k]);
    check("chg_drop_cnt", drop_cnt_b, 0);
    check("chg_busy", busy_b, 0);
    @(posedge clk); #1;

    // reset mid-packet with a drop recorded
    push_pkt(32'h5A5A0F0F);
    pulse_rdy(32'h5A5A0F0F);
    @(posedge clk); #1;
    cntlr_data = 32'h11111111;
    cntlr_data_rdy = 1'b1;
    @(posedge clk); #1;
    cntlr_data = 32'h22222222;
    @(posedge clk); #1;
    cntlr_data_rdy = 1'b0;
    sb_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("mid_byte3", tx_data, 8'h0F);
    check("mid_drop_before", drop_cnt, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_busy", busy, 0);
    sb_en = 1'b1;
    @(posedge clk); #1;
    run_until_idle(10, 1'b0);
    clear_stats();
    push_pkt(32'hC0FFEE01);
    pulse_rdy(32'hC0FFEE01);
    @(negedge clk);
    check("fresh_valid", tx_valid, 1);
    check("fresh_sync", tx_data, 8'hA5);
    @(posedge clk); #1;
    run_until_idle(30, 1'b0);
    check("fresh_hs_cnt", hs_cnt, 6);

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
